display_framebuffer: RTL and testbench
======================================

DISPLAY_FRAMEBUFFER -- requirements
Module: display_framebuffer

Interface
REQ-001 Parameter segments, default 1, number of parallel display segments read per address.
REQ-002 Parameter rows, default 8, addressable rows per segment.
REQ-003 Parameter columns, default 32, pixels per row.
REQ-004 Parameter bitwidth, default 8, bits per colour channel; one pixel word is PW = 3*bitwidth bits.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 row  in  $clog2(rows)  read row address from display_driver.
REQ-008 column  in  $clog2(columns)  read column address from display_driver.
REQ-009 frame_complete  in  1  one-cycle pulse from display_driver marking the end of a full frame scan.
REQ-010 pixel  out  PW*segments  registered read data; lane s occupies bits [PW*s +: PW].
REQ-011 wr_en  in  1  write strobe for one pixel into the back bank.
REQ-012 wr_seg  in  SW  target segment; SW = $clog2(segments) if segments>1, else 1 (ignored).
REQ-013 wr_row  in  $clog2(rows)  write row address.
REQ-014 wr_col  in  $clog2(columns)  write column address.
REQ-015 wr_data  in  PW  pixel word {blue, green, red}, red in the LSBs.
REQ-016 wr_ready  out  1  high when writes are accepted.
REQ-017 swap_req  in  1  one-cycle pulse; the writer has finished the back bank.
REQ-018 swap_pending  out  1  high while a swap is waiting for frame_complete.
REQ-019 swap_done  out  1  one-cycle pulse after a bank swap takes effect.
REQ-020 front_bank  out  1  index (0/1) of the bank currently read by the display.

Function
REQ-021 Storage: two banks (0, 1), each segments*rows*columns words of PW bits; the front bank is read-only and the other bank (back) is write-only.
REQ-022 Read latency: row/column sampled at edge N; pixel valid after edge N+1 (exactly 1 cycle), all lanes from the same {row, column} of the front bank.
REQ-023 Read out-of-range: row >= rows or column >= columns yields an all-zero pixel word on every lane.
REQ-024 Write: wr_en && wr_ready at edge N stores wr_data at back[wr_seg][wr_row][wr_col]; the write is visible to reads only after a swap.
REQ-025 Write out-of-range: wr_seg >= segments, wr_row >= rows, or wr_col >= columns makes the write a no-op with no other effect.
REQ-026 Write while wr_ready=0 is discarded.
REQ-027 Swap FSM states: IDLE (wr_ready=1, swap_pending=0) and PENDING (wr_ready=0, swap_pending=1).
REQ-028 IDLE -> PENDING on the edge where swap_req=1; a write presented on that same edge is accepted.
REQ-029 In IDLE, frame_complete has no effect; swap_req and frame_complete together on the same edge enter PENDING without swapping.
REQ-030 In PENDING, swap_req is ignored; on the edge where frame_complete=1, front_bank toggles and the FSM returns to IDLE.
REQ-031 swap_done=1 for exactly the one cycle following the toggle edge; otherwise 0.
REQ-032 A read sampled on the toggle edge uses the old front bank; reads sampled after it use the new one.
REQ-033 At most one swap per swap_req; a frame_complete arriving while there is no request never changes front_bank.

Reset
REQ-034 When rst=1 at an edge: front_bank=0, FSM=IDLE, pixel=0, wr_ready=1 is visible after that edge, swap_pending=0, swap_done=0.
REQ-035 Memory contents are not cleared by reset; any pending swap is abandoned; writes and swap_req are ignored while rst=1.
REQ-036 After reset deasserts, normal operation begins on the next edge with no warm-up cycles.

Verification
REQ-037 Reset, write bank1[0][2][5]=0x112233, swap_req, frame_complete, read row=2 col=5 -> pixel=0x112233 one cycle later, front_bank=1, swap_done pulses once.
REQ-038 swap_req, then wr_en with data 0xFFFFFF while swap_pending=1 -> wr_ready=0 and the back-bank contents are unchanged after a swap.
REQ-039 swap_req and frame_complete on the same edge -> no toggle; the next frame_complete toggles front_bank.
REQ-040 rows=6: read row=7 -> pixel=0; write wr_row=7 -> no bank change.
REQ-041 segments=2: write lane0=0xAA0000 and lane1=0x0000BB at the same {row, col}, then swap -> pixel=0x0000BB_AA0000.
REQ-042 rst asserted while swap_pending=1 -> front_bank=0 and swap_pending=0; a subsequent frame_complete causes no toggle.

Source files
------------

// File: rtl/display_framebuffer_if.sv
// Bus between the display driver / pixel writer and the double-buffered framebuffer.
// The framebuffer takes the slave side; the driver/writer (or a bench) takes master.
interface display_framebuffer_if #(
    parameter int segments = 1,
    parameter int rows     = 8,
    parameter int columns  = 32,
    parameter int bitwidth = 8
);
    localparam int PW = 3 * bitwidth;
    localparam int SW = (segments > 1) ? $clog2(segments) : 1;
    localparam int RW = (rows > 1) ? $clog2(rows) : 1;
    localparam int CW = (columns > 1) ? $clog2(columns) : 1;

    // display read port
    logic [RW-1:0]          row;
    logic [CW-1:0]          column;
    logic                   frame_complete;
    logic [PW*segments-1:0] pixel;

    // back-bank write port
    logic                   wr_en;
    logic [SW-1:0]          wr_seg;
    logic [RW-1:0]          wr_row;
    logic [CW-1:0]          wr_col;
    logic [PW-1:0]          wr_data;
    logic                   wr_ready;

    // bank swap handshake
    logic                   swap_req;
    logic                   swap_pending;
    logic                   swap_done;
    logic                   front_bank;

    modport master (
        output row, column, frame_complete, wr_en, wr_seg, wr_row, wr_col,
               wr_data, swap_req,
        input  pixel, wr_ready, swap_pending, swap_done, front_bank
    );

    modport slave (
        input  row, column, frame_complete, wr_en, wr_seg, wr_row, wr_col,
               wr_data, swap_req,
        output pixel, wr_ready, swap_pending, swap_done, front_bank
    );
endinterface

// File: rtl/display_framebuffer.sv
// Double-buffered framebuffer: the display reads the front bank with one cycle
// of latency while a writer fills the back bank; a requested swap waits for the
// end of the current frame scan so the display never shows a torn frame.
module display_framebuffer #(
    parameter int segments = 1,
    parameter int rows     = 8,
    parameter int columns  = 32,
    parameter int bitwidth = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    display_framebuffer_if.slave  bus
);
    localparam int PW = 3 * bitwidth;
    localparam int SW = (segments > 1) ? $clog2(segments) : 1;
    localparam int RW = (rows > 1) ? $clog2(rows) : 1;
    localparam int CW = (columns > 1) ? $clog2(columns) : 1;

    typedef enum logic {IDLE, PENDING} swap_state_t;

    swap_state_t state;
    logic        front_q;
    logic        wr_ready_q;
    logic        pending_q;
    logic        done_q;

    logic [PW-1:0] mem [0:1][0:segments-1][0:rows-1][0:columns-1];

    logic [segments-1:0][PW-1:0] rd_lanes;
    logic [segments-1:0][PW-1:0] pixel_q;

    logic rd_row_ok, rd_col_ok, wr_row_ok, wr_col_ok, wr_seg_ok;

    // Address range checks; a dimension that fills its address width can
    // never be out of range, so only partial dimensions get a comparator.
    generate
        if (rows == (1 << RW)) begin : g_row_full
            assign rd_row_ok = 1'b1;
            assign wr_row_ok = 1'b1;
        end else begin : g_row_part
            assign rd_row_ok = ({{(32-RW){1'b0}}, bus.row}    < 32'(rows));
            assign wr_row_ok = ({{(32-RW){1'b0}}, bus.wr_row} < 32'(rows));
        end

        if (columns == (1 << CW)) begin : g_col_full
            assign rd_col_ok = 1'b1;
            assign wr_col_ok = 1'b1;
        end else begin : g_col_part
            assign rd_col_ok = ({{(32-CW){1'b0}}, bus.column} < 32'(columns));
            assign wr_col_ok = ({{(32-CW){1'b0}}, bus.wr_col} < 32'(columns));
        end

        if (segments == (1 << SW) || segments == 1) begin : g_seg_full
            assign wr_seg_ok = 1'b1;
        end else begin : g_seg_part
            assign wr_seg_ok = ({{(32-SW){1'b0}}, bus.wr_seg} < 32'(segments));
        end

        // every lane reads the same {row, column} of its own segment
        for (genvar s = 0; s < segments; s++) begin : g_lane
            assign rd_lanes[s] = mem[front_q][s][bus.row][bus.column];
        end
    endgenerate

    logic rd_ok;
    logic wr_fire;
    logic [SW-1:0] wr_seg_idx;

    assign rd_ok      = rd_row_ok && rd_col_ok;
    assign wr_fire    = bus.wr_en && wr_ready_q && !rst &&
                        wr_seg_ok && wr_row_ok && wr_col_ok;
    assign wr_seg_idx = (segments > 1) ? bus.wr_seg : '0;

    // Back-bank write port; storage is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[~front_q][wr_seg_idx][bus.wr_row][bus.wr_col] <= bus.wr_data;
    end

    // Registered read; front_q is the pre-edge value, so a read sampled on a
    // swap edge still returns the old front bank.
    always_ff @(posedge clk) begin
        if (rst)
            pixel_q <= '0;
        else
            pixel_q <= rd_ok ? rd_lanes : '0;
    end

    // Swap FSM: request parks in PENDING until the driver finishes a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            front_q    <= 1'b0;
            wr_ready_q <= 1'b1;
            pending_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // frame_complete is irrelevant here, even alongside swap_req
                    if (bus.swap_req) begin
                        state      <= PENDING;
                        wr_ready_q <= 1'b0;
                        pending_q  <= 1'b1;
                    end
                end
                PENDING: begin
                    if (bus.frame_complete) begin
                        state      <= IDLE;
                        front_q    <= ~front_q;
                        wr_ready_q <= 1'b1;
                        pending_q  <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    wr_ready_q <= 1'b1;
                    pending_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pixel        = pixel_q;
    assign bus.wr_ready     = wr_ready_q;
    assign bus.swap_pending = pending_q;
    assign bus.swap_done    = done_q;
    assign bus.front_bank   = front_q;
endmodule

// File: tb/tb_display_framebuffer.sv
// Randomized bench for display_framebuffer (2 segments, 6 rows, 12 columns) with
// a behavioural model: banks as plain arrays, a front index and a pending flag.
module tb_display_framebuffer;
    localparam int SEGS = 2;
    localparam int ROWS = 6;
    localparam int COLS = 12;
    localparam int BW   = 8;
    localparam int PW   = 3 * BW;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    display_framebuffer_if #(.segments(SEGS), .rows(ROWS), .columns(COLS), .bitwidth(BW)) bus ();

    display_framebuffer #(.segments(SEGS), .rows(ROWS), .columns(COLS), .bitwidth(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // model state; arrays cover the full address space so out-of-range
    // indices can be handled by explicit rules rather than array bounds
    logic [PW-1:0] mdl [0:1][0:1][0:7][0:15];
    int            m_front;
    bit            m_pend;
    bit            m_done;
    logic [2*PW-1:0] m_pix;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply the rules of one clock edge to the model, using the inputs as
    // they stand right before the edge.
    task automatic model_edge();
        if (rst) begin
            m_front = 0;
            m_pend  = 0;
            m_done  = 0;
            m_pix   = '0;
        end else begin
            for (int s = 0; s < SEGS; s++)
                m_pix[s*PW +: PW] = (int'(bus.row) < ROWS && int'(bus.column) < COLS)
                                    ? mdl[m_front][s][bus.row][bus.column] : '0;
            if (!m_pend && bus.wr_en && int'(bus.wr_row) < ROWS &&
                int'(bus.wr_col) < COLS && int'(bus.wr_seg) < SEGS)
                mdl[1-m_front][bus.wr_seg][bus.wr_row][bus.wr_col] = bus.wr_data;
            m_done = 0;
            if (!m_pend) begin
                if (bus.swap_req) m_pend = 1;
            end else if (bus.frame_complete) begin
                m_front = 1 - m_front;
                m_pend  = 0;
                m_done  = 1;
            end
        end
    endtask

    // one clock: advance model, then check every output shortly after the edge
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("pixel",        64'(bus.pixel),        64'(m_pix));
        chk("front_bank",   64'(bus.front_bank),   64'(m_front));
        chk("swap_pending", 64'(bus.swap_pending), 64'(m_pend));
        chk("wr_ready",     64'(bus.wr_ready),     64'(!m_pend));
        chk("swap_done",    64'(bus.swap_done),    64'(m_done));
    endtask

    task automatic clear_in();
        bus.row = '0; bus.column = '0; bus.frame_complete = 1'b0;
        bus.wr_en = 1'b0; bus.wr_seg = '0; bus.wr_row = '0; bus.wr_col = '0;
        bus.wr_data = '0; bus.swap_req = 1'b0;
    endtask

    task automatic wr(input int s, input int r, input int c, input logic [PW-1:0] d);
        bus.wr_en = 1'b1; bus.wr_seg = 1'(s); bus.wr_row = 3'(r);
        bus.wr_col = 4'(c); bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic do_swap();
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
        bus.frame_complete = 1'b1;
        step();
        bus.frame_complete = 1'b0;
    endtask

    task automatic rd(input int r, input int c);
        bus.row = 3'(r); bus.column = 4'(c);
        step();
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        m_front = 0; m_pend = 0; m_done = 0; m_pix = '0;
        for (int b = 0; b < 2; b++)
            for (int s = 0; s < 2; s++)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 16; c++)
                        mdl[b][s][r][c] = '0;
        step();
        step();
        rst = 1'b0;

        // fill both banks so every later read has a known value
        for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < SEGS; s++)
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        wr(s, r, c, PW'($urandom));
            do_swap();
        end

        // basic write / swap / read-back
        wr(0, 2, 5, 24'h112233);
        bus.swap_req = 1'b1; step(); bus.swap_req = 1'b0;
        bus.frame_complete = 1'b1; step(); bus.frame_complete = 1'b0;
        chk("basic_done", 64'(bus.swap_done), 64'd1);
        rd(2, 5);
        chk("basic_pix", 64'(bus.pixel[PW-1:0]), 64'h112233);
        chk("basic_front", 64'(bus.front_bank), 64'd1);
        chk("basic_done_once", 64'(bus.swap_done), 64'd0);

        // write while pending is dropped
        bus.swap_req = 1'b1; step(); bus.swap_req = 1'b0;
        chk("pend_ready", 64'(bus.wr_ready), 64'd0);
        wr(0, 1, 1, 24'hFFFFFF);
        bus.frame_complete = 1'b1; step(); bus.frame_complete = 1'b0;
        rd(1, 1);
        chk("pend_wr_dropped", 64'(bus.pixel[PW-1:0] == 24'hFFFFFF), 64'd0);

        // swap_req together with frame_complete does not swap
        bus.swap_req = 1'b1; bus.frame_complete = 1'b1; step();
        bus.swap_req = 1'b0;
        chk("same_edge_front", 64'(bus.front_bank), 64'd0);
        chk("same_edge_pend", 64'(bus.swap_pending), 64'd1);
        step();
        bus.frame_complete = 1'b0;
        chk("next_fc_front", 64'(bus.front_bank), 64'd1);

        // out-of-range reads and writes
        rd(7, 3);
        chk("oor_row_pix", 64'(bus.pixel), 64'd0);
        rd(2, 13);
        chk("oor_col_pix", 64'(bus.pixel), 64'd0);
        wr(0, 7, 3, 24'hABCDEF);
        wr(1, 3, 14, 24'h123456);

        // two lanes at the same address
        wr(0, 3, 4, 24'hAA0000);
        wr(1, 3, 4, 24'h0000BB);
        do_swap();
        rd(3, 4);
        chk("lanes_pix", 64'(bus.pixel), 64'h0000BB_AA0000);

        // reset abandons a pending swap
        bus.swap_req = 1'b1; step(); bus.swap_req = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_front", 64'(bus.front_bank), 64'd0);
        chk("rst_pend", 64'(bus.swap_pending), 64'd0);
        bus.frame_complete = 1'b1; step(); bus.frame_complete = 1'b0;
        chk("rst_no_toggle", 64'(bus.front_bank), 64'd0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            bus.row            = 3'($urandom_range(0, 7));
            bus.column         = 4'($urandom_range(0, 15));
            bus.wr_en          = ($urandom_range(0, 9) < 6);
            bus.wr_seg         = 1'($urandom);
            bus.wr_row         = 3'($urandom_range(0, 7));
            bus.wr_col         = 4'($urandom_range(0, 15));
            bus.wr_data        = PW'($urandom);
            bus.swap_req       = ($urandom_range(0, 9) == 0);
            bus.frame_complete = ($urandom_range(0, 6) == 0);
            rst                = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;
        clear_in();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
